// File: rtl/scr1_tcm_arb_pkg.sv
// Shared types for the TCM arbiter: scr1 memory-interface enums, grant encoding and byte-enable helper.
package scr1_tcm_arb_pkg;

    localparam int SCR1_IMEM_AWIDTH = 32;
    localparam int SCR1_IMEM_DWIDTH = 32;
    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;
    localparam int SCR1_TCM_BE_W    = 4;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_IMEM = 2'b01,
        GRANT_DMEM = 2'b10
    } type_scr1_tcm_grant_e;

    // SRAM word-address width; a 4-byte TCM still needs a one-bit port.
    function automatic int scr1_tcm_mem_aw(input logic [31:0] size);
        return ($clog2(size) > 2) ? $clog2(size) - 2 : 1;
    endfunction

    function automatic logic [SCR1_TCM_BE_W-1:0] scr1_tcm_be(input type_scr1_mem_width_e width,
                                                           input logic [1:0]           offset);
        case (width)
            SCR1_MEM_WIDTH_BYTE:  return 4'b0001 << offset;
            SCR1_MEM_WIDTH_HWORD: return 4'b0011 << offset;
            default:              return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/scr1_tcm_arb_if.sv
// Core imem/dmem request buses plus the single-port SRAM port, as seen by the TCM arbiter.
interface scr1_tcm_arb_if
    import scr1_tcm_arb_pkg::*;
#(
    parameter logic [31:0] SCR1_TCM_SIZE = 32'h00010000
);
    localparam int MEM_AW = scr1_tcm_mem_aw(SCR1_TCM_SIZE);

    logic                          imem_req;
    type_scr1_mem_cmd_e            imem_cmd;
    logic [SCR1_IMEM_AWIDTH-1:0]   imem_addr;
    logic                          imem_req_ack;
    logic [SCR1_IMEM_DWIDTH-1:0]   imem_rdata;
    type_scr1_mem_resp_e           imem_resp;

    logic                          dmem_req;
    type_scr1_mem_cmd_e            dmem_cmd;
    type_scr1_mem_width_e          dmem_width;
    logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr;
    logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata;
    logic                          dmem_req_ack;
    logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata;
    type_scr1_mem_resp_e           dmem_resp;

    logic                          mem_req;
    logic                          mem_we;
    logic [SCR1_TCM_BE_W-1:0]      mem_be;
    logic [MEM_AW-1:0]             mem_addr;
    logic [31:0]                   mem_wdata;
    logic [31:0]                   mem_rdata;

    // Environment side: core requesters and the SRAM macro.
    modport master (
        output imem_req, imem_cmd, imem_addr,
        input  imem_req_ack, imem_rdata, imem_resp,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  imem_req, imem_cmd, imem_addr,
        output imem_req_ack, imem_rdata, imem_resp,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/scr1_tcm_arb_lane.sv
// Per-requester response lane: registers the grant outcome and aligns SRAM read data one cycle later.
module scr1_tcm_arb_lane
    import scr1_tcm_arb_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        grant,
    input  logic                        err,
    input  logic                        wr,
    input  logic [1:0]                  offset,
    input  logic [31:0]                 mem_rdata,
    output type_scr1_mem_resp_e         resp,
    output logic [SCR1_DMEM_DWIDTH-1:0] rdata
);

    type_scr1_mem_resp_e resp_q;
    logic                rd_pend;
    logic [1:0]          off_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_q  <= SCR1_MEM_RESP_NOTRDY;
            rd_pend <= 1'b0;
            off_q   <= 2'b00;
        end else begin
            resp_q  <= SCR1_MEM_RESP_NOTRDY;
            rd_pend <= 1'b0;
            if (grant) begin
                resp_q  <= err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                rd_pend <= !err && !wr;
                off_q   <= offset;
            end
        end
    end

    // A response due while rst_n is low is suppressed immediately, not one edge later.
    assign resp  = rst_n ? resp_q : SCR1_MEM_RESP_NOTRDY;
    assign rdata = (rst_n && rd_pend) ? (mem_rdata >> {off_q, 3'b000}) : '0;

endmodule

// File: rtl/scr1_tcm_arb.sv
// Arbiter sharing one 1-cycle single-port TCM between imem and dmem; dmem has fixed priority.
// Define SCR1_TCM_ARB_STARVE_EN to force an imem win after STARVE_LIMIT consecutive losses.
module scr1_tcm_arb
    import scr1_tcm_arb_pkg::*;
#(
    parameter logic [31:0] SCR1_TCM_SIZE = 32'h00010000,
    parameter logic [31:0] SCR1_TCM_BASE = 32'h00480000,
    parameter int          STARVE_LIMIT  = 4
)(
    input  logic            clk,
    input  logic            rst_n,
    scr1_tcm_arb_if.slave   bus
);

    localparam int MEM_AW = scr1_tcm_mem_aw(SCR1_TCM_SIZE);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("scr1_tcm_arb: STARVE_LIMIT must be in 1..15");
    end

    type_scr1_tcm_grant_e  grant;
    logic                  imem_v;
    logic                  dmem_v;
    logic                  force_imem;
    type_scr1_mem_cmd_e    sel_cmd;
    type_scr1_mem_width_e  sel_width;
    logic [31:0]           sel_addr;
    logic [31:0]           sel_wdata;
    logic [31:0]           off;
    logic                  misal;
    logic                  err;
    logic                  access;

    assign imem_v = rst_n && bus.imem_req;
    assign dmem_v = rst_n && bus.dmem_req;

`ifdef SCR1_TCM_ARB_STARVE_EN
    logic [3:0] starve_cnt;

    assign force_imem = (starve_cnt == 4'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n || !imem_v || grant == GRANT_IMEM) starve_cnt <= 4'd0;
        else                                          starve_cnt <= starve_cnt + 4'd1;
    end
`else
    assign force_imem = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = GRANT_NONE;
        if (dmem_v && !(imem_v && force_imem)) grant = GRANT_DMEM;
        else if (imem_v)                       grant = GRANT_IMEM;
    end

    // imem fetches are always full words and carry no write data.
    always_comb begin
        sel_cmd   = SCR1_MEM_CMD_RD;
        sel_width = SCR1_MEM_WIDTH_WORD;
        sel_addr  = '0;
        sel_wdata = '0;
        case (grant)
            GRANT_IMEM: begin
                sel_cmd  = bus.imem_cmd;
                sel_addr = bus.imem_addr;
            end
            GRANT_DMEM: begin
                sel_cmd   = bus.dmem_cmd;
                sel_width = bus.dmem_width;
                sel_addr  = bus.dmem_addr;
                sel_wdata = bus.dmem_wdata;
            end
            default: ;
        endcase
    end

    // Base is size-aligned, so the low offset bits equal the low address bits.
    assign off = sel_addr - SCR1_TCM_BASE;

    always_comb begin
        misal = 1'b0;
        case (sel_width)
            SCR1_MEM_WIDTH_HWORD: misal = off[0];
            SCR1_MEM_WIDTH_WORD:  misal = |off[1:0];
            default:              misal = 1'b0;
        endcase
    end

    assign err    = (off >= SCR1_TCM_SIZE) || misal ||
                    (grant == GRANT_IMEM && sel_cmd == SCR1_MEM_CMD_WR);
    assign access = (grant != GRANT_NONE) && !err;

    assign bus.imem_req_ack = (grant == GRANT_IMEM);
    assign bus.dmem_req_ack = (grant == GRANT_DMEM);

    assign bus.mem_req   = access;
    assign bus.mem_we    = access && (sel_cmd == SCR1_MEM_CMD_WR);
    assign bus.mem_be    = access ? scr1_tcm_be(sel_width, off[1:0]) : '0;
    assign bus.mem_addr  = MEM_AW'(off >> 2);
    assign bus.mem_wdata = sel_wdata << {off[1:0], 3'b000};

    scr1_tcm_arb_lane u_imem_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant     (grant == GRANT_IMEM),
        .err       (err),
        .wr        (sel_cmd == SCR1_MEM_CMD_WR),
        .offset    (off[1:0]),
        .mem_rdata (bus.mem_rdata),
        .resp      (bus.imem_resp),
        .rdata     (bus.imem_rdata)
    );

    scr1_tcm_arb_lane u_dmem_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant     (grant == GRANT_DMEM),
        .err       (err),
        .wr        (sel_cmd == SCR1_MEM_CMD_WR),
        .offset    (off[1:0]),
        .mem_rdata (bus.mem_rdata),
        .resp      (bus.dmem_resp),
        .rdata     (bus.dmem_rdata)
    );

endmodule

// File: tb/tb_scr1_tcm_arb.sv
// Bench for scr1_tcm_arb: byte-level memory model checked every cycle plus hand-computed directed checks.
// Build with SCR1_TCM_ARB_STARVE_EN defined to exercise the starvation guard.
module tb_scr1_tcm_arb;
    import scr1_tcm_arb_pkg::*;

    localparam logic [31:0] SIZE  = 32'h00010000;
    localparam logic [31:0] BASE  = 32'h00480000;
    localparam int          LIMIT = 4;
    localparam int          NWORD = 16384;

    logic clk;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    scr1_tcm_arb_if #(.SCR1_TCM_SIZE(SIZE)) bus ();

    scr1_tcm_arb #(
        .SCR1_TCM_SIZE (SIZE),
        .SCR1_TCM_BASE (BASE),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] word_init(input int i);
        return (i == 4) ? 32'hDEADBEEF : ((i * 32'h01000193) ^ 32'h5A5A0F0F);
    endfunction

    // SRAM macro: one-cycle read latency, byte-lane writes, preloaded on the first edge.
    logic [31:0] sram [0:NWORD-1];
    bit          sram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!sram_loaded) begin
            for (int i = 0; i < NWORD; i++) sram[i] <= word_init(i);
            sram_loaded <= 1'b1;
        end else if (bus.mem_req) begin
            bus.mem_rdata <= sram[bus.mem_addr];
            if (bus.mem_we)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    // Reference model: TCM contents as a byte array; responses expected on the following cycle.
    logic [7:0]          ref_mem [0:SIZE-1];
    bit                  ref_loaded = 1'b0;
    type_scr1_mem_resp_e m_i_resp = SCR1_MEM_RESP_NOTRDY;
    type_scr1_mem_resp_e m_d_resp = SCR1_MEM_RESP_NOTRDY;
    logic [31:0]         m_i_rdata = '0;
    logic [31:0]         m_d_rdata = '0;
    int                  losses = 0;

    always @(negedge clk) begin
        logic        i_r, d_r, force_i, i_win, d_win, is_wr, legal;
        logic [31:0] a, wd, o, word, tmp;
        logic [3:0]  be_exp;
        int          n;

        if (!ref_loaded) begin
            for (int i = 0; i < NWORD; i++) begin
                tmp = word_init(i);
                for (int b = 0; b < 4; b++) ref_mem[4*i+b] = tmp[8*b +: 8];
            end
            ref_loaded = 1'b1;
        end

        check("imem_resp",  bus.imem_resp,  rst_n ? m_i_resp  : SCR1_MEM_RESP_NOTRDY);
        check("imem_rdata", bus.imem_rdata, rst_n ? m_i_rdata : 32'h0);
        check("dmem_resp",  bus.dmem_resp,  rst_n ? m_d_resp  : SCR1_MEM_RESP_NOTRDY);
        check("dmem_rdata", bus.dmem_rdata, rst_n ? m_d_rdata : 32'h0);

        i_r = rst_n && bus.imem_req;
        d_r = rst_n && bus.dmem_req;
`ifdef SCR1_TCM_ARB_STARVE_EN
        force_i = (losses >= LIMIT);
`else
        force_i = 1'b0;
`endif
        d_win = d_r && !(i_r && force_i);
        i_win = i_r && !d_win;
        losses = (!i_r || i_win) ? 0 : losses + 1;

        check("imem_req_ack", bus.imem_req_ack, i_win);
        check("dmem_req_ack", bus.dmem_req_ack, d_win);

        m_i_resp  = SCR1_MEM_RESP_NOTRDY;
        m_d_resp  = SCR1_MEM_RESP_NOTRDY;
        m_i_rdata = '0;
        m_d_rdata = '0;
        legal     = 1'b0;
        is_wr     = 1'b0;
        a = '0; wd = '0; n = 4;

        if (i_win) begin
            a = bus.imem_addr;
            is_wr = (bus.imem_cmd == SCR1_MEM_CMD_WR);
            n = 4;
        end else if (d_win) begin
            a = bus.dmem_addr;
            wd = bus.dmem_wdata;
            is_wr = (bus.dmem_cmd == SCR1_MEM_CMD_WR);
            n = (bus.dmem_width == SCR1_MEM_WIDTH_BYTE) ? 1 :
                (bus.dmem_width == SCR1_MEM_WIDTH_HWORD) ? 2 : 4;
        end

        if (i_win || d_win) begin
            o = a - BASE;
            legal = (a >= BASE) && (a < BASE + SIZE) && (a % n == 0) && !(i_win && is_wr);
            if (legal && !is_wr) begin
                word = {ref_mem[o-o%4+3], ref_mem[o-o%4+2], ref_mem[o-o%4+1], ref_mem[o-o%4]};
                tmp  = word >> (8 * (o % 4));
            end else begin
                tmp = '0;
            end
            if (i_win) begin
                m_i_resp  = legal ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
                m_i_rdata = tmp;
            end else begin
                m_d_resp  = legal ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
                m_d_rdata = tmp;
            end
        end

        be_exp = '0;
        if (legal) for (int b = 0; b < n; b++) be_exp[(a % 4) + b] = 1'b1;

        check("mem_req", bus.mem_req, legal);
        check("mem_we",  bus.mem_we,  legal && is_wr);
        check("mem_be",  bus.mem_be,  be_exp);
        if (legal) begin
            check("mem_addr", bus.mem_addr, (a - BASE) / 4);
            if (is_wr) begin
                check("mem_wdata", bus.mem_wdata, wd << (8 * (a % 4)));
                for (int b = 0; b < n; b++) ref_mem[a - BASE + b] = wd[8*b +: 8];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.imem_req   = 1'b0;
        bus.imem_cmd   = SCR1_MEM_CMD_RD;
        bus.imem_addr  = '0;
        bus.dmem_req   = 1'b0;
        bus.dmem_cmd   = SCR1_MEM_CMD_RD;
        bus.dmem_width = SCR1_MEM_WIDTH_WORD;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
    endtask

    task automatic ireq(input type_scr1_mem_cmd_e cmd, input logic [31:0] addr);
        bus.imem_req  = 1'b1;
        bus.imem_cmd  = cmd;
        bus.imem_addr = addr;
    endtask

    task automatic dreq(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                        input logic [31:0] addr, input logic [31:0] wdata);
        bus.dmem_req   = 1'b1;
        bus.dmem_cmd   = cmd;
        bus.dmem_width = w;
        bus.dmem_addr  = addr;
        bus.dmem_wdata = wdata;
    endtask

    typedef struct {
        type_scr1_mem_cmd_e   cmd;
        type_scr1_mem_width_e w;
        logic [31:0]          addr;
        logic [31:0]          wdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_ack;

        vecs[0] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h00480006, 32'h0000BEEF};
        vecs[1] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h00480024, 32'h11223344};
        vecs[2] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h00480026, 32'h0};
        vecs[3] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h00480004, 32'h0};
        vecs[4] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h00480025, 32'h0};
        vecs[5] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h0048FFFC, 32'h0};
        vecs[6] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'h0048FFFF, 32'h0000005C};
        vecs[7] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h0048FFFF, 32'h0};

        // Reset: a pending write request must not reach the SRAM.
        rst_n = 1'b0;
        idle();
        dreq(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE, 32'hFFFFFFFF);
        step();
        #3;
        check("rst_mem_req",    bus.mem_req, 1'b0);
        check("rst_mem_we",     bus.mem_we,  1'b0);
        check("rst_mem_be",     bus.mem_be,  4'b0000);
        check("rst_imem_resp",  bus.imem_resp, SCR1_MEM_RESP_NOTRDY);
        check("rst_dmem_resp",  bus.dmem_resp, SCR1_MEM_RESP_NOTRDY);
        check("rst_imem_rdata", bus.imem_rdata, 32'h0);
        check("rst_dmem_rdata", bus.dmem_rdata, 32'h0);
        step();
        rst_n = 1'b1;
        idle();
        step();

        // Single imem read.
        ireq(SCR1_MEM_CMD_RD, 32'h00480010);
        #3;
        check("ird_ack",      bus.imem_req_ack, 1'b1);
        check("ird_mem_req",  bus.mem_req, 1'b1);
        check("ird_mem_addr", bus.mem_addr, 32'd4);
        check("ird_mem_we",   bus.mem_we, 1'b0);
        step();
        idle();
        #3;
        check("ird_resp",  bus.imem_resp, SCR1_MEM_RESP_RDY_OK);
        check("ird_rdata", bus.imem_rdata, 32'hDEADBEEF);
        step();

        // Conflict: dmem first, imem the cycle after.
        ireq(SCR1_MEM_CMD_RD, 32'h00480010);
        dreq(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h00480020, 32'h0);
        #3;
        check("cf_dmem_ack", bus.dmem_req_ack, 1'b1);
        check("cf_imem_ack", bus.imem_req_ack, 1'b0);
        step();
        bus.dmem_req = 1'b0;
        #3;
        check("cf_imem_ack2",  bus.imem_req_ack, 1'b1);
        check("cf_dmem_resp",  bus.dmem_resp, SCR1_MEM_RESP_RDY_OK);
        check("cf_imem_wait",  bus.imem_resp, SCR1_MEM_RESP_NOTRDY);
        step();
        idle();
        #3;
        check("cf_imem_resp",  bus.imem_resp, SCR1_MEM_RESP_RDY_OK);
        check("cf_imem_rdata", bus.imem_rdata, 32'hDEADBEEF);
        step();

        // Byte write then read back at byte offset 3.
        dreq(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h00480003, 32'h000000A5);
        #3;
        check("bw_mem_be",    bus.mem_be, 4'b1000);
        check("bw_mem_wdata", {24'h0, bus.mem_wdata[31:24]}, 32'h000000A5);
        step();
        dreq(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h00480003, 32'h0);
        #3;
        check("bw_resp",  bus.dmem_resp, SCR1_MEM_RESP_RDY_OK);
        check("bw_rdata", bus.dmem_rdata, 32'h0);
        step();
        idle();
        #3;
        check("br_resp",  bus.dmem_resp, SCR1_MEM_RESP_RDY_OK);
        check("br_byte",  {24'h0, bus.dmem_rdata[7:0]}, 32'h000000A5);
        step();

        // Back-to-back dmem vectors, including the last TCM word.
        foreach (vecs[k]) begin
            dreq(vecs[k].cmd, vecs[k].w, vecs[k].addr, vecs[k].wdata);
            step();
        end
        idle();
        step();

        // Error cases: misaligned, out of range on both sides, imem write.
        dreq(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h00480002, 32'h0);
        #3;
        check("er_mis_mem_req", bus.mem_req, 1'b0);
        check("er_mis_ack",     bus.dmem_req_ack, 1'b1);
        step();
        dreq(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h00490000, 32'h0);
        #3;
        check("er_mis_resp",    bus.dmem_resp, SCR1_MEM_RESP_RDY_ER);
        check("er_mis_rdata",   bus.dmem_rdata, 32'h0);
        check("er_oor_mem_req", bus.mem_req, 1'b0);
        step();
        dreq(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h0047FFFF, 32'h00000077);
        #3;
        check("er_oor_resp",    bus.dmem_resp, SCR1_MEM_RESP_RDY_ER);
        check("er_low_mem_req", bus.mem_req, 1'b0);
        step();
        dreq(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h00480001, 32'h0);
        step();
        idle();
        ireq(SCR1_MEM_CMD_WR, 32'h00480010);
        #3;
        check("er_half_resp", bus.dmem_resp, SCR1_MEM_RESP_RDY_ER);
        check("er_iwr_ack",   bus.imem_req_ack, 1'b1);
        check("er_iwr_mem",   bus.mem_req, 1'b0);
        step();
        idle();
        #3;
        check("er_iwr_resp",  bus.imem_resp, SCR1_MEM_RESP_RDY_ER);
        check("er_iwr_rdata", bus.imem_rdata, 32'h0);
        step();

        // Continuous contention with both requests held.
        ireq(SCR1_MEM_CMD_RD, 32'h00480010);
        dreq(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h00480030, 32'h0);
        for (int k = 0; k < 6; k++) begin
`ifdef SCR1_TCM_ARB_STARVE_EN
            exp_ack = (k == LIMIT);
`else
            exp_ack = 1'b0;
`endif
            #3;
            check("starve_imem_ack", bus.imem_req_ack, exp_ack);
            step();
        end
        bus.dmem_req = 1'b0;
        #3;
        check("starve_release", bus.imem_req_ack, 1'b1);
        step();
        idle();
        step();

        // Alternating requesters, one grant per cycle.
        for (int k = 0; k < 6; k++) begin
            idle();
            if (k % 2 == 0) ireq(SCR1_MEM_CMD_RD, BASE + 32'(8 * k));
            else dreq(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, BASE + 32'(8 * k + 2), 32'h0);
            step();
        end
        idle();
        step();

        // Reset asserted in the response cycle.
        dreq(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h00480010, 32'h0);
        #3;
        check("rm_ack", bus.dmem_req_ack, 1'b1);
        step();
        idle();
        rst_n = 1'b0;
        #3;
        check("rm_dmem_resp",  bus.dmem_resp, SCR1_MEM_RESP_NOTRDY);
        check("rm_imem_resp",  bus.imem_resp, SCR1_MEM_RESP_NOTRDY);
        check("rm_dmem_rdata", bus.dmem_rdata, 32'h0);
        step();
        rst_n = 1'b1;
        #3;
        check("rm_dmem_after", bus.dmem_resp, SCR1_MEM_RESP_NOTRDY);
        check("rm_imem_after", bus.imem_resp, SCR1_MEM_RESP_NOTRDY);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
